// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Message types and requester IDs shared by the memory request arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam int c_OPAQ_BITS = 8;

   localparam logic REQ_IMEM = 1'b0;
   localparam logic REQ_DMEM = 1'b1;

   typedef struct packed {
      logic [c_OPAQ_BITS-1:0] opaque;
      logic [2:0]             type_;
      logic [31:0]            addr;
      logic [1:0]             len;
      logic [31:0]            data;
   } mem_req_t;

   typedef struct packed {
      logic [c_OPAQ_BITS-1:0] opaque;
      logic [2:0]             type_;
      logic [31:0]            addr;
      logic [1:0]             len;
      logic [31:0]            data;
   } mem_resp_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_route_fifo.sv
// ============================================================================
// Module : mem_arb_route_fifo
// Brief  : 1-bit route FIFO remembering which requester owns each outstanding
//          memory request; head steers the next in-order response.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_route_fifo #(
   parameter int P_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  logic i_push_id,
   input  logic i_pop,
   output logic o_full,
   output logic o_empty,
   output logic o_head
);

   localparam int c_AW = $clog2(P_DEPTH);

   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;
   logic [P_DEPTH-1:0] r_ids;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // A push into a full FIFO only happens alongside a pop, so overwriting the head slot is safe.
   always_ff @(posedge clk) begin
      if (i_push) r_ids[r_wr_ptr[c_AW-1:0]] <= i_push_id;
   end

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign o_head  = r_ids[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// ============================================================================
// Module : mem_req_arbiter
// Brief  : Round-robin sharing of one memory port between imem and dmem, with
//          in-order response routing. Optional MEM_ARB_STATS_EN adds counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int P_MAX_INFLIGHT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_go,
   input  logic [1:0]       i_req_val,
   output logic [1:0]       o_req_rdy,
   input  mem_req_t [1:0]   i_req_msg,
   output logic [1:0]       o_resp_val,
   input  logic [1:0]       i_resp_rdy,
   output mem_resp_t [1:0]  o_resp_msg,
   output logic             o_mem_req_val,
   input  logic             i_mem_req_rdy,
   output mem_req_t         o_mem_req_msg,
   input  logic             i_mem_resp_val,
   output logic             o_mem_resp_rdy,
   input  mem_resp_t        i_mem_resp_msg,
`ifdef MEM_ARB_STATS_EN
   output logic [1:0][31:0] o_grant_cnt,
   output logic [31:0]      o_stall_cnt,
`endif
   output logic             o_orphan_err
);

   logic r_ptr;
   logic r_orphan;
   logic w_full;
   logic w_empty;
   logic w_head;
   logic w_gnt;
   logic w_can_issue;
   logic w_push;
   logic w_pop;
   logic w_resp_live;

   mem_arb_route_fifo #(
      .P_DEPTH (P_MAX_INFLIGHT)
   ) u_route_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_push_id (w_gnt),
      .i_pop     (w_pop),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_head    (w_head)
   );

   assign w_resp_live = rst & i_mem_resp_val & !w_empty;
   assign w_pop       = w_resp_live & i_resp_rdy[w_head];
   // Freeing a slot this cycle lets a new grant go out in the same cycle.
   assign w_can_issue = rst & i_go & i_mem_req_rdy & (!w_full | w_pop);
   assign w_gnt       = (&i_req_val) ? r_ptr : (i_req_val[REQ_DMEM] ? REQ_DMEM : REQ_IMEM);
   assign w_push      = w_can_issue & (|i_req_val);

   assign o_mem_req_val = w_push;
   assign o_mem_req_msg = i_req_msg[w_gnt];

   always_comb begin
      o_req_rdy        = '0;
      o_req_rdy[w_gnt] = w_can_issue & i_req_val[w_gnt];
   end

   always_comb begin
      o_resp_val         = '0;
      o_resp_val[w_head] = w_resp_live;
   end

   assign o_resp_msg     = {2{i_mem_resp_msg}};
   assign o_mem_resp_rdy = rst & (w_empty | i_resp_rdy[w_head]);
   assign o_orphan_err   = r_orphan;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr    <= REQ_IMEM;
         r_orphan <= 1'b0;
      end else begin
         if (w_push) r_ptr <= ~w_gnt;
         if (i_mem_resp_val && w_empty) r_orphan <= 1'b1;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [1:0][31:0] r_grant_cnt;
   logic [31:0]      r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_grant_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_push) r_grant_cnt[w_gnt] <= r_grant_cnt[w_gnt] + 32'd1;
         if ((|i_req_val) && i_go && !w_can_issue) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign o_grant_cnt = r_grant_cnt;
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// ============================================================================
// Module : tb_mem_req_arbiter
// Brief  : Self-checking bench: vector table, directed corner sequences and a
//          randomized run against a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_req_arbiter;
   import mem_arb_pkg::*;

   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            go;
   logic [1:0]      rv;
   logic [1:0]      rdy;
   mem_req_t [1:0]  rmsg;
   logic [1:0]      resp_val;
   logic [1:0]      rr;
   mem_resp_t [1:0] resp_msg;
   logic            mreq_val;
   logic            mrr;
   mem_req_t        mreq_msg;
   logic            mrv;
   logic            mresp_rdy;
   mem_resp_t       mrmsg;
   logic            orphan_err;
`ifdef MEM_ARB_STATS_EN
   logic [1:0][31:0] grant_cnt;
   logic [31:0]      stall_cnt;
`endif

   mem_req_arbiter #(.P_MAX_INFLIGHT(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_go           (go),
      .i_req_val      (rv),
      .o_req_rdy      (rdy),
      .i_req_msg      (rmsg),
      .o_resp_val     (resp_val),
      .i_resp_rdy     (rr),
      .o_resp_msg     (resp_msg),
      .o_mem_req_val  (mreq_val),
      .i_mem_req_rdy  (mrr),
      .o_mem_req_msg  (mreq_msg),
      .i_mem_resp_val (mrv),
      .o_mem_resp_rdy (mresp_rdy),
      .i_mem_resp_msg (mrmsg),
`ifdef MEM_ARB_STATS_EN
      .o_grant_cnt    (grant_cnt),
      .o_stall_cnt    (stall_cnt),
`endif
      .o_orphan_err   (orphan_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   int total = 0;
   int bad   = 0;

   // Reference model: queue of owner IDs for outstanding requests.
   int          q[$];
   int          prefer = 0;
   bit          m_orphan = 1'b0;
   int unsigned gcnt[2];
   int unsigned scnt = 0;

   typedef struct {
      logic       rst;
      logic       go;
      logic [1:0] rv;
      logic       mrr;
      logic       mrv;
      logic [1:0] rr;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic mem_req_t rand_req();
      mem_req_t r;
      r.opaque = c_OPAQ_BITS'($urandom);
      r.type_  = 3'($urandom);
      r.addr   = $urandom;
      r.len    = 2'($urandom);
      r.data   = $urandom;
      return r;
   endfunction

   function automatic logic [127:0] ctrl_bus();
      return 128'({mreq_val, rdy, resp_val, mresp_rdy, orphan_err});
   endfunction

   // One clock cycle with inputs already driven: compare against the model, then advance it.
   task automatic cycle();
      bit         pop, issue, anyv;
      int         w;
      logic [1:0] e_rdy, e_rv;
      logic       e_mresp;
      #1;
      anyv  = |rv;
      pop   = rst && mrv && q.size() > 0 && rr[q[0]];
      issue = rst && go && mrr && (q.size() < DEPTH || pop);
      w     = (rv == 2'b11) ? prefer : (rv[1] ? 1 : 0);
      e_rdy = 2'b00;
      if (issue && anyv) e_rdy[w] = 1'b1;
      e_rv = 2'b00;
      if (rst && mrv && q.size() > 0) e_rv[q[0]] = 1'b1;
      e_mresp = !rst ? 1'b0 : (q.size() == 0 ? 1'b1 : rr[q[0]]);
      check("ctrl", ctrl_bus(), 128'({issue && anyv, e_rdy, e_rv, e_mresp, m_orphan}));
      if (issue && anyv) check("req_msg", 128'(mreq_msg), 128'(rmsg[w]));
      if (e_rv != 2'b00) check("resp_msg", 128'(resp_msg[q[0]]), 128'(mrmsg));
      @(posedge clk);
      if (!rst) begin
         q.delete();
         prefer   = 0;
         m_orphan = 1'b0;
         gcnt[0]  = 0;
         gcnt[1]  = 0;
         scnt     = 0;
      end else begin
         if (mrv && q.size() == 0) m_orphan = 1'b1;
         if (anyv && go && !issue) scnt++;
         if (pop) void'(q.pop_front());
         if (issue && anyv) begin
            q.push_back(w);
            prefer = 1 - w;
            gcnt[w]++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [2:0] e4 [6];
      logic [1:0] rr4 [6];

      tbl[0]  = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 7'b0000000};
      tbl[1]  = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 2'b11, 7'b0000010};
      tbl[2]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 7'b1010010};
      tbl[3]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 7'b1100010};
      tbl[4]  = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 2'b11, 7'b1010110};
      tbl[5]  = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 2'b01, 7'b0001000};
      tbl[6]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 2'b11, 7'b0001010};
      tbl[7]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 7'b1100110};
      tbl[8]  = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 2'b11, 7'b0001010};
      tbl[9]  = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 2'b11, 7'b0000010};
      tbl[10] = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'b11, 7'b0000011};
      tbl[11] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'b11, 7'b0000001};
      tbl[12] = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'b11, 7'b0000010};

      rst = 1'b0; go = 1'b0; rv = 2'b00; mrr = 1'b1; mrv = 1'b0; rr = 2'b11;
      rmsg[0] = rand_req(); rmsg[1] = rand_req(); mrmsg = rand_req();
      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         rst = tbl[i].rst; go = tbl[i].go; rv = tbl[i].rv;
         mrr = tbl[i].mrr; mrv = tbl[i].mrv; rr = tbl[i].rr;
         #1;
         check($sformatf("vec%0d", i), ctrl_bus(), 128'(tbl[i].exp));
         @(posedge clk);
         @(negedge clk);
      end

      rst = 1'b0; rv = 2'b00; mrv = 1'b0; go = 1'b0;
      repeat (2) cycle();
      rst = 1'b1;

      // go low holds off grants; then strict alternation starting with imem
      rv = 2'b11;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t1_hold", 128'({mreq_val, rdy}), 128'(3'b000));
         cycle();
      end
      go = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t1_order", 128'(rdy), 128'((k % 2) ? 2'b10 : 2'b01));
         cycle();
      end
      rv = 2'b00; mrv = 1'b1;
      repeat (4) cycle();

      // full FIFO blocks grants; a pop admits a new grant in the same cycle
      rv = 2'b01; mrv = 1'b0;
      repeat (4) cycle();
      #1;
      check("t3_full", 128'(rdy), 128'(2'b00));
      cycle();
      mrv = 1'b1;
      #1;
      check("t3_pop_push", 128'({rdy, mresp_rdy, resp_val}), 128'(5'b01101));
      cycle();
      rv = 2'b00;
      repeat (4) cycle();

      // dmem-only stream with two-cycle memory latency
      rv = 2'b10; mrv = 1'b0;
      for (int k = 0; k < 5; k++) begin
         rv = (k < 3) ? 2'b10 : 2'b00;
         rmsg[1].addr = 32'h100 + 32'(4 * k);
         mrv = (k >= 2);
         mrmsg.data = 32'h100 + 32'(4 * (k - 2));
         if (k >= 2) begin
            #1;
            check("t2_route", 128'({resp_val, resp_msg[1].data}), 128'({2'b10, 32'h100 + 32'(4 * (k - 2))}));
         end
         cycle();
      end
      mrv = 1'b0;

      // interleaved owners, dmem stalls its response for three cycles
      rmsg[0].addr = 32'h0; rmsg[1].addr = 32'h200;
      rv = 2'b01; cycle();
      rv = 2'b10; cycle();
      rv = 2'b01; rmsg[0].addr = 32'h4; cycle();
      rv = 2'b00; mrv = 1'b1;
      e4  = '{3'b011, 3'b100, 3'b100, 3'b100, 3'b101, 3'b011};
      rr4 = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
      for (int k = 0; k < 6; k++) begin
         rr = rr4[k];
         #1;
         check($sformatf("t4_step%0d", k), 128'({resp_val, mresp_rdy}), 128'(e4[k]));
         cycle();
      end
      mrv = 1'b0; rr = 2'b11;

      // reset with requests in flight, then a stray response
      rv = 2'b11;
      repeat (2) cycle();
      rst = 1'b0; rv = 2'b00;
      cycle();
      rst = 1'b1; mrv = 1'b1;
      #1;
      check("t5_stray", 128'({resp_val, mresp_rdy}), 128'(3'b001));
      cycle();
      mrv = 1'b0;
      #1;
      check("t5_orphan", 128'(orphan_err), 128'(1'b1));
      cycle();

      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) != 0);
         go  = ($urandom_range(0, 9) != 0);
         rv  = 2'($urandom);
         mrr = ($urandom_range(0, 3) != 0);
         mrv = 1'($urandom);
         rr  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         rmsg[0] = rand_req(); rmsg[1] = rand_req(); mrmsg = rand_req();
         cycle();
      end

`ifdef MEM_ARB_STATS_EN
      #1;
      check("rand_grant_cnt", 128'(grant_cnt), 128'({gcnt[1], gcnt[0]}));
      check("rand_stall_cnt", 128'(stall_cnt), 128'(scnt));
      rst = 1'b0; rv = 2'b00; mrv = 1'b0;
      cycle();
      rst = 1'b1; go = 1'b1; mrr = 1'b1; rr = 2'b11;
      for (int k = 0; k < 12; k++) begin
         rv  = (k < 7) ? 2'b01 : 2'b10;
         mrv = (q.size() > 0);
         cycle();
      end
      #1;
      check("t6_grant_cnt", 128'(grant_cnt), 128'({32'd5, 32'd7}));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
